// File: rtl/z_result_stage_pkg.sv
// Shared types for the Z result stage: default word width, head read state, result entry.
package z_result_stage_pkg;

  localparam int unsigned Z_WIDTH = 32;

  typedef enum logic [1:0] {
    FRESH,
    LO_DONE,
    HI_DONE
  } rd_state_e;

  typedef struct packed {
    logic               wide;
    logic [Z_WIDTH-1:0] hi;
    logic [Z_WIDTH-1:0] lo;
  } z_entry_t;

endpackage

// File: rtl/z_entry_fifo.sv
// DEPTH-entry circular buffer with push/pop and occupancy count; head is always visible.
module z_entry_fifo #(
  parameter int unsigned DW    = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!clear_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (clear_n && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/z_result_stage.sv
// Captures ALU results as Z-low/Z-high pairs and returns them on the CPU bus under read strobes.
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = Z_WIDTH,
  parameter int unsigned DEPTH       = 2,
  parameter bit          SEXT_NARROW = 1'b1
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       res_lo,
  input  logic [WIDTH-1:0]       res_hi,
  input  logic                   res_wide,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic                   rd_lo,
  input  logic                   rd_hi,
  output logic [WIDTH-1:0]       bus_data,
  output logic                   bus_valid,
  output logic                   rd_err,
  output logic                   zero_flag,
  output logic                   neg_flag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             wide;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } entry_t;

  entry_t     wr_entry;
  entry_t     head;
  rd_state_e  state_q;
  rd_state_e  state_d;
  logic       empty;
  logic       push;
  logic       pop;
  logic       rd_any;
  logic       rd_ok;
  logic       rd_bad;
  logic [WIDTH-1:0] rd_word;

  assign empty     = (count == '0);
  assign res_ready = clear_n && (count < CW'(DEPTH));
  assign push      = res_valid && res_ready && !flush;

  // Narrow results carry their extension word so rd_hi on them is meaningful.
  always_comb begin
    wr_entry.lo   = res_lo;
    wr_entry.wide = res_wide;
    if (res_wide)         wr_entry.hi = res_hi;
    else if (SEXT_NARROW) wr_entry.hi = {WIDTH{res_lo[WIDTH-1]}};
    else                  wr_entry.hi = '0;
  end

  z_entry_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .clear_n (clear_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head),
    .count   (count)
  );

  assign rd_any  = rd_lo || rd_hi;
  assign rd_ok   = rd_any && !empty && !flush;
  assign rd_bad  = rd_any && !flush && (empty || (rd_lo && rd_hi));
  assign rd_word = rd_lo ? head.lo : head.hi;

  // Head read FSM; rd_lo wins when both strobes are raised.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (rd_ok) begin
      unique case (state_q)
        FRESH: begin
          if (!rd_lo)         state_d = HI_DONE;
          else if (head.wide) state_d = LO_DONE;
          else                pop     = 1'b1;
        end
        LO_DONE: pop = !rd_lo;
        HI_DONE: pop = rd_lo;
        default: state_d = FRESH;
      endcase
      if (pop) state_d = FRESH;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n || flush) begin
      state_q   <= FRESH;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_valid <= rd_ok;
      rd_err    <= rd_bad;
      if (rd_ok) bus_data <= rd_word;
    end
  end

  assign zero_flag = !empty && (head.lo == '0) && (head.hi == '0);
  assign neg_flag  = !empty && (head.wide ? head.hi[WIDTH-1] : head.lo[WIDTH-1]);

endmodule

// File: tb/tb_z_result_stage.sv
// Directed and randomized checks of z_result_stage against a queue-based result model.
module tb_z_result_stage;

  localparam int W = 32;
  localparam int D = 2;

  logic          clock = 1'b0;
  logic          clear_n = 1'b0, flush = 1'b0, res_wide = 1'b0, res_valid = 1'b0;
  logic          rd_lo = 1'b0, rd_hi = 1'b0;
  logic [W-1:0]  res_lo = '0, res_hi = '0;
  logic [W-1:0]  bus_data;
  logic          res_ready, bus_valid, rd_err, zero_flag, neg_flag;
  logic [1:0]    count;

  always #5 clock = ~clock;

  z_result_stage #(.WIDTH(W), .DEPTH(D), .SEXT_NARROW(1'b1)) dut (
    .clock(clock), .clear_n(clear_n), .flush(flush),
    .res_lo(res_lo), .res_hi(res_hi), .res_wide(res_wide), .res_valid(res_valid),
    .res_ready(res_ready), .rd_lo(rd_lo), .rd_hi(rd_hi),
    .bus_data(bus_data), .bus_valid(bus_valid), .rd_err(rd_err),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .count(count)
  );

  // Model: a queue of held results; the head pops once every half it owes has been read.
  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    bit           wide;
  } ent_t;

  ent_t         q[$];
  bit           seen_lo, seen_hi;
  logic [W-1:0] m_data = '0;
  bit           m_valid, m_err;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic cycle(input bit cn, input bit fl, input bit v, input bit w,
                       input logic [W-1:0] lo, input logic [W-1:0] hi,
                       input bit rl, input bit rh);
    bit rdy;
    clear_n = cn; flush = fl; res_valid = v; res_wide = w;
    res_lo = lo; res_hi = hi; rd_lo = rl; rd_hi = rh;
    rdy = cn && (q.size() < D);
    if (!cn || fl) begin
      q.delete(); seen_lo = 0; seen_hi = 0;
      m_data = '0; m_valid = 0; m_err = 0;
    end else begin
      m_valid = (rl || rh) && (q.size() > 0);
      m_err   = (rl || rh) && ((q.size() == 0) || (rl && rh));
      if (m_valid) begin
        m_data = rl ? q[0].lo : q[0].hi;
        if (rl) seen_lo = 1; else seen_hi = 1;
        if (q[0].wide ? (seen_lo && seen_hi) : seen_lo) begin
          void'(q.pop_front());
          seen_lo = 0; seen_hi = 0;
        end
      end
      if (v && rdy) q.push_back('{lo, w ? hi : {W{lo[W-1]}}, w});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();                                   cycle(1, 0, 0, 0, '0, '0, 0, 0); endtask
  task automatic push_n(input logic [W-1:0] lo);           cycle(1, 0, 1, 0, lo, '0, 0, 0); endtask
  task automatic push_w(input logic [W-1:0] lo, input logic [W-1:0] hi); cycle(1, 0, 1, 1, lo, hi, 0, 0); endtask
  task automatic rd(input bit rl, input bit rh);           cycle(1, 0, 0, 0, '0, '0, rl, rh); endtask

  task automatic test_reset();
    cycle(0, 0, 1, 0, 32'h1234, '0, 1, 0);
    cycle(0, 0, 1, 0, 32'h1234, '0, 0, 0);
    n_vec++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (bus_data !== 32'h0 || bus_valid !== 1'b0 || rd_err !== 1'b0) begin n_err++; $display("FAIL reset_bus: data %h valid %b err %b want 0 0 0", bus_data, bus_valid, rd_err); end
    n_vec++; if (zero_flag !== 1'b0 || neg_flag !== 1'b0) begin n_err++; $display("FAIL reset_flags: z %b n %b want 0 0", zero_flag, neg_flag); end
    n_vec++; if (res_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b want 0", res_ready); end
    idle();
    n_vec++; if (res_ready !== 1'b1 || count !== 2'd0) begin n_err++; $display("FAIL reset_ready_high: ready %b count %0d want 1 0", res_ready, count); end
  endtask

  task automatic test_narrow();
    push_n(32'hF000_0000);
    n_vec++; if (count !== 2'd1 || neg_flag !== 1'b1 || zero_flag !== 1'b0) begin n_err++; $display("FAIL narrow_push: count %0d n %b z %b want 1 1 0", count, neg_flag, zero_flag); end
    rd(1, 0);
    n_vec++; if (bus_data !== 32'hF000_0000 || bus_valid !== 1'b1) begin n_err++; $display("FAIL narrow_read: data %h valid %b want f0000000 1", bus_data, bus_valid); end
    n_vec++; if (count !== 2'd0 || neg_flag !== 1'b0) begin n_err++; $display("FAIL narrow_pop: count %0d n %b want 0 0", count, neg_flag); end
    idle();
    n_vec++; if (bus_valid !== 1'b0 || bus_data !== 32'hF000_0000) begin n_err++; $display("FAIL narrow_hold: valid %b data %h want 0 f0000000", bus_valid, bus_data); end
  endtask

  task automatic test_extension();
    push_n(32'h8000_0001);
    rd(0, 1);
    n_vec++; if (bus_data !== 32'hFFFF_FFFF || bus_valid !== 1'b1 || count !== 2'd1) begin n_err++; $display("FAIL ext_hi: data %h valid %b count %0d want ffffffff 1 1", bus_data, bus_valid, count); end
    rd(1, 0);
    n_vec++; if (bus_data !== 32'h8000_0001 || count !== 2'd0) begin n_err++; $display("FAIL ext_lo: data %h count %0d want 80000001 0", bus_data, count); end
  endtask

  task automatic test_wide();
    push_w(32'h0, 32'h1);
    n_vec++; if (zero_flag !== 1'b0 || neg_flag !== 1'b0 || count !== 2'd1) begin n_err++; $display("FAIL wide_flags: z %b n %b count %0d want 0 0 1", zero_flag, neg_flag, count); end
    rd(1, 0);
    rd(1, 0);
    n_vec++; if (bus_data !== 32'h0 || bus_valid !== 1'b1 || count !== 2'd1) begin n_err++; $display("FAIL wide_reread: data %h valid %b count %0d want 0 1 1", bus_data, bus_valid, count); end
    rd(0, 1);
    n_vec++; if (bus_data !== 32'h1 || count !== 2'd0) begin n_err++; $display("FAIL wide_hi: data %h count %0d want 1 0", bus_data, count); end
  endtask

  task automatic test_back_pressure();
    push_n(32'hA);
    push_n(32'hB);
    n_vec++; if (count !== 2'd2 || res_ready !== 1'b0) begin n_err++; $display("FAIL full_state: count %0d ready %b want 2 0", count, res_ready); end
    push_n(32'hC);
    n_vec++; if (count !== 2'd2) begin n_err++; $display("FAIL full_stall: count %0d want 2", count); end
    cycle(1, 0, 1, 0, 32'hC, '0, 1, 0);
    n_vec++; if (count !== 2'd1 || bus_data !== 32'hA || res_ready !== 1'b1) begin n_err++; $display("FAIL pop_no_bypass: count %0d data %h ready %b want 1 a 1", count, bus_data, res_ready); end
    push_n(32'hC);
    n_vec++; if (count !== 2'd2) begin n_err++; $display("FAIL after_pop_push: count %0d want 2", count); end
    rd(1, 0);
    rd(1, 0);
    n_vec++; if (bus_data !== 32'hC || count !== 2'd0) begin n_err++; $display("FAIL drain_order: data %h count %0d want c 0", bus_data, count); end
  endtask

  task automatic test_errors();
    rd(1, 0);
    n_vec++; if (rd_err !== 1'b1 || bus_valid !== 1'b0 || bus_data !== 32'hC) begin n_err++; $display("FAIL empty_read: err %b valid %b data %h want 1 0 c", rd_err, bus_valid, bus_data); end
    idle();
    n_vec++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %b want 0", rd_err); end
    push_w(32'h1234_5678, 32'h9ABC_DEF0);
    rd(1, 1);
    n_vec++; if (bus_data !== 32'h1234_5678 || rd_err !== 1'b1 || bus_valid !== 1'b1 || count !== 2'd1) begin n_err++; $display("FAIL both_strobes: data %h err %b valid %b count %0d want 12345678 1 1 1", bus_data, rd_err, bus_valid, count); end
    rd(0, 1);
    n_vec++; if (bus_data !== 32'h9ABC_DEF0 || count !== 2'd0 || rd_err !== 1'b0) begin n_err++; $display("FAIL both_then_hi: data %h count %0d err %b want 9abcdef0 0 0", bus_data, count, rd_err); end
  endtask

  task automatic test_flush_reset();
    for (int k = 0; k < 2; k++) begin
      push_w(32'h1, 32'h8000_0000);
      push_n(32'h5);
      rd(1, 0);
      n_vec++; if (count !== 2'd2 || neg_flag !== 1'b1) begin n_err++; $display("FAIL mid_setup%0d: count %0d n %b want 2 1", k, count, neg_flag); end
      if (k == 0) cycle(1, 1, 0, 0, '0, '0, 0, 1);
      else        cycle(0, 0, 0, 0, '0, '0, 0, 1);
      n_vec++; if (count !== 2'd0 || zero_flag !== 1'b0 || neg_flag !== 1'b0 || bus_valid !== 1'b0 || rd_err !== 1'b0) begin n_err++; $display("FAIL discard%0d: count %0d z %b n %b valid %b err %b want 0 0 0 0 0", k, count, zero_flag, neg_flag, bus_valid, rd_err); end
      push_w(32'hAA, 32'hBB);
      rd(0, 1);
      n_vec++; if (bus_data !== 32'hBB || count !== 2'd1) begin n_err++; $display("FAIL restart_fresh%0d: data %h count %0d want bb 1", k, bus_data, count); end
      rd(1, 0);
      n_vec++; if (bus_data !== 32'hAA || count !== 2'd0) begin n_err++; $display("FAIL restart_pop%0d: data %h count %0d want aa 0", k, bus_data, count); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit cn, fl, v, w, rl, rh;
      logic [W-1:0] lo, hi;
      logic exp_z, exp_n;
      cn = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 2) != 0);
      w  = $urandom_range(0, 1) == 1;
      lo = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      hi = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      rl = ($urandom_range(0, 2) == 0);
      rh = ($urandom_range(0, 2) == 0);
      cycle(cn, fl, v, w, lo, hi, rl, rh);
      exp_z = (q.size() > 0) && (q[0].lo == '0) && (q[0].hi == '0);
      exp_n = (q.size() > 0) && (q[0].wide ? q[0].hi[W-1] : q[0].lo[W-1]);
      n_vec++; if (bus_data !== m_data) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", i, bus_data, m_data); end
      n_vec++; if (bus_valid !== m_valid || rd_err !== m_err) begin n_err++; $display("FAIL rnd_strobe[%0d]: valid %b err %b want %b %b", i, bus_valid, rd_err, m_valid, m_err); end
      n_vec++; if (count !== 2'(q.size()) || res_ready !== (cn && q.size() < D)) begin n_err++; $display("FAIL rnd_count[%0d]: count %0d ready %b want %0d %b", i, count, res_ready, q.size(), cn && q.size() < D); end
      n_vec++; if (zero_flag !== exp_z || neg_flag !== exp_n) begin n_err++; $display("FAIL rnd_flags[%0d]: z %b n %b want %b %b", i, zero_flag, neg_flag, exp_z, exp_n); end
    end
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_extension();
    test_wide();
    test_back_pressure();
    test_errors();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
